// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command path: FSM states, command record,
// angle limit and servo frame period.
package servo_pkg;

  typedef enum logic [1:0] {IDLE, RAMP, DWELL} state_t;

  typedef struct packed {
    logic [7:0] angle;
    logic [7:0] dwell;
  } cmd_t;

  localparam logic [7:0] ANGLE_MAX = 8'd180;

  // 20 ms servo frame expressed in 100 MHz clocks
  localparam int FRAME_PERIOD_CLKS = 2_000_000;

  function automatic logic [7:0] clamp_angle(input logic [7:0] a);
    return (a > ANGLE_MAX) ? ANGLE_MAX : a;
  endfunction

endpackage

// File: rtl/servo_cmd_fifo.sv
// Show-ahead command FIFO: rd_data always presents the oldest entry, pop retires it.
module servo_cmd_fifo
  import servo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t wr_data,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage holds data only; pointers alone define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/servo_cmd_sequencer.sv
// Servo command sequencer: queues (angle, dwell) commands, ramps pos_deg per frame and
// drives pw_ticks for the PWM generator. Optional autonomous sweep: SERVO_SEQ_SWEEP_EN.
module servo_cmd_sequencer
  import servo_pkg::*;
#(
  parameter int INIT_DEG   = 90,
  parameter int STEP_DEG   = 1,
  parameter int BASE_TICKS = 100,
  parameter int SPAN_MUL   = 142,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_angle,
  input  logic [7:0]  cmd_dwell,
  input  logic        sweep_en,
  output logic [7:0]  pos_deg,
  output logic [15:0] pw_ticks,
  output logic        busy,
  output logic        at_target
);

  localparam logic [7:0] INIT_POS = 8'(INIT_DEG);

  function automatic logic [7:0] step_toward(input logic [7:0] p, input logic [7:0] t);
    logic [8:0] diff;
    logic [8:0] stp;
    stp = 9'(STEP_DEG);
    if (t > p) begin
      diff = {1'b0, t} - {1'b0, p};
      return p + 8'((diff < stp) ? diff : stp);
    end else begin
      diff = {1'b0, p} - {1'b0, t};
      return p - 8'((diff < stp) ? diff : stp);
    end
  endfunction

  function automatic logic [15:0] scale_pw(input logic [7:0] p);
    logic [15:0] prod;
    prod = 16'(p) * 16'(SPAN_MUL);
    return 16'(BASE_TICKS) + (prod >> 8);
  endfunction

  state_t      state, state_nxt;
  logic [7:0]  pos, pos_nxt;
  logic [7:0]  tgt, tgt_nxt;
  logic [7:0]  dwell_cnt, dwell_nxt;
  logic        at_tgt_nxt;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  cmd_t        push_cmd;
  cmd_t        head;
  logic [15:0] pw_p1;

`ifdef SERVO_SEQ_SWEEP_EN
  logic sweep_up, sweep_up_nxt;
`else
  logic sweep_unused;
  assign sweep_unused = sweep_en;
`endif

  assign push_cmd.angle = clamp_angle(cmd_angle);
  assign push_cmd.dwell = cmd_dwell;
  assign cmd_ready      = !fifo_full;

  servo_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid && cmd_ready),
    .pop     (pop),
    .wr_data (push_cmd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    tgt_nxt    = tgt;
    dwell_nxt  = dwell_cnt;
    at_tgt_nxt = 1'b0;
    pop        = 1'b0;
`ifdef SERVO_SEQ_SWEEP_EN
    sweep_up_nxt = sweep_up;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tgt_nxt   = head.angle;
          dwell_nxt = head.dwell;
          state_nxt = RAMP;
        end
`ifdef SERVO_SEQ_SWEEP_EN
        else if (sweep_en) begin
          tgt_nxt   = sweep_up ? ANGLE_MAX : 8'd0;
          dwell_nxt = 8'd0;
          state_nxt = RAMP;
        end
`endif
      end
      // Arrival is checked every clock so a target equal to pos exits without a frame
      RAMP: begin
        if (pos == tgt) begin
          at_tgt_nxt = 1'b1;
          state_nxt  = DWELL;
`ifdef SERVO_SEQ_SWEEP_EN
          sweep_up_nxt = !sweep_up;
`endif
        end else if (frame_tick) begin
          pos_nxt = step_toward(pos, tgt);
        end
      end
      DWELL: begin
        if (frame_tick) begin
          if (dwell_cnt == 8'd0) state_nxt = IDLE;
          else                   dwell_nxt = dwell_cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pos       <= INIT_POS;
      at_target <= 1'b0;
      pw_p1     <= scale_pw(INIT_POS);
`ifdef SERVO_SEQ_SWEEP_EN
      sweep_up  <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      at_target <= at_tgt_nxt;
      pw_p1     <= scale_pw(pos);
`ifdef SERVO_SEQ_SWEEP_EN
      sweep_up  <= sweep_up_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    tgt       <= tgt_nxt;
    dwell_cnt <= dwell_nxt;
  end

  assign pos_deg  = pos;
  assign pw_ticks = pw_p1;
  assign busy     = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Directed bench for servo_cmd_sequencer: default instance plus a STEP_DEG=50 instance.
module tb_servo_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        sweep_en = 1'b0;

  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_angle = '0;
  logic [7:0]  cmd_dwell = '0;
  logic        cmd_ready, busy, at_target;
  logic [7:0]  pos_deg;
  logic [15:0] pw_ticks;

  logic        s_cmd_valid = 1'b0;
  logic [7:0]  s_cmd_angle = '0;
  logic [7:0]  s_cmd_dwell = '0;
  logic        s_cmd_ready, s_busy, s_at_target;
  logic [7:0]  s_pos_deg;
  logic [15:0] s_pw_ticks;

  int nvec = 0;
  int nmis = 0;
  int at_cnt = 0;
  int s_at_cnt = 0;
  int xfer_cnt = 0;

  servo_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_angle(cmd_angle), .cmd_dwell(cmd_dwell), .sweep_en(sweep_en),
    .pos_deg(pos_deg), .pw_ticks(pw_ticks), .busy(busy), .at_target(at_target)
  );

  servo_cmd_sequencer #(.STEP_DEG(50)) dut_s (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_angle(s_cmd_angle), .cmd_dwell(s_cmd_dwell), .sweep_en(sweep_en),
    .pos_deg(s_pos_deg), .pw_ticks(s_pw_ticks), .busy(s_busy), .at_target(s_at_target)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (at_target)               at_cnt   <= at_cnt + 1;
    if (s_at_target)             s_at_cnt <= s_at_cnt + 1;
    if (cmd_valid && cmd_ready)  xfer_cnt <= xfer_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_angle = a;
    cmd_dwell = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_accepted", 32'(n < 50), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at0, x0, n;

    // Reset state
    cyc(3);
    chk("rst_pos", pos_deg, 90);
    chk("rst_pw", pw_ticks, 149);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_at_target", at_target, 0);
    rst_n = 1'b1;
    cyc(20);
    chk("idle_pos", pos_deg, 90);
    chk("idle_pw", pw_ticks, 149);
    chk("idle_busy", busy, 0);
    chk("idle_ready", cmd_ready, 1);

    // Clamp and no-overshoot on the STEP_DEG=50 instance
    s_cmd_valid = 1'b1; s_cmd_angle = 8'd200; s_cmd_dwell = 8'd0;
    cyc(1);
    s_cmd_valid = 1'b0;
    cyc(2);
    tick();
    chk("s_pos_step1", s_pos_deg, 140);
    tick();
    chk("s_pos_step2", s_pos_deg, 180);
    tick();
    tick();
    cyc(2);
    chk("s_pos_final", s_pos_deg, 180);
    chk("s_pw_final", s_pw_ticks, 199);
    chk("s_at_cnt", s_at_cnt, 1);
    chk("s_busy_end", s_busy, 0);
    chk("ignored_ticks_pos", pos_deg, 90);

    // Ramp 90 -> 45 with dwell 2
    push(8'd45, 8'd2);
    cyc(2);
    at0 = at_cnt;
    repeat (44) tick();
    chk("ramp45_pos44", pos_deg, 46);
    chk("ramp45_no_early_at", at_cnt - at0, 0);
    tick();
    chk("ramp45_pos", pos_deg, 45);
    cyc(3);
    chk("ramp45_at_once", at_cnt - at0, 1);
    chk("ramp45_pw", pw_ticks, 124);
    tick();
    tick();
    chk("dwell_busy", busy, 1);
    tick();
    cyc(1);
    chk("dwell_done_idle", busy, 0);

    // Back-to-back commands fill the FIFO while ramping
    push(8'd50, 8'd0);
    cyc(2);
    push(8'd50, 8'd0);
    push(8'd50, 8'd0);
    push(8'd50, 8'd0);
    push(8'd50, 8'd0);
    chk("full_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_angle = 8'd60; cmd_dwell = 8'd0;
    x0 = xfer_cnt;
    cyc(5);
    chk("full_no_xfer", xfer_cnt - x0, 0);
    repeat (7) tick();
    chk("full_before_pop", xfer_cnt - x0, 0);
    chk("full_before_pop_ready", cmd_ready, 0);
    n = 0;
    while (xfer_cnt == x0 && n < 6) begin
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    chk("fifth_xfer", xfer_cnt - x0, 1);
    n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    chk("drain_done", busy, 0);
    cyc(2);
    chk("drain_pos", pos_deg, 60);
    chk("drain_pw", pw_ticks, 133);

    // Target equal to position at pop time
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    at0 = at_cnt;
    push(8'd90, 8'd0);
    cyc(4);
    chk("same_at_pulse", at_cnt - at0, 1);
    chk("same_pos", pos_deg, 90);
    chk("same_busy", busy, 1);
    tick();
    cyc(1);
    chk("same_idle", busy, 0);

    // Reset mid-ramp with commands queued
    push(8'd0, 8'd0);
    cyc(2);
    repeat (30) tick();
    chk("mid_pos", pos_deg, 60);
    push(8'd10, 8'd0);
    push(8'd20, 8'd0);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_pos", pos_deg, 90);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_at", at_target, 0);
    chk("abort_pw", pw_ticks, 149);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    repeat (3) tick();
    chk("post_abort_busy", busy, 0);
    chk("post_abort_pos", pos_deg, 90);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
